// File: rtl/t9990_reg_pkg.sv
// Register-field encodings and scan FSM states shared by the blitter address path.
// Latency: none (definitions only).
// Backpressure: not applicable.
package t9990_reg;

    typedef enum logic [1:0] {
        CLRM_2BPP  = 2'd0,
        CLRM_4BPP  = 2'd1,
        CLRM_8BPP  = 2'd2,
        CLRM_16BPP = 2'd3
    } clrm_e;

    typedef enum logic [1:0] {
        XIMM_256  = 2'd0,
        XIMM_512  = 2'd1,
        XIMM_1024 = 2'd2,
        XIMM_2048 = 2'd3
    } ximm_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // P1 layout always addresses a 1024-pixel-wide plane.
    localparam logic [4:0] P1_WIDTH_LOG2 = 5'd10;

    // log2 of the image width in pixels, before clipping to the X counter width.
    function automatic logic [4:0] width_log2(input logic [1:0] ximm, input logic p1);
        logic [4:0] lw;
        lw = 5'd8;
        if (p1) begin
            lw = P1_WIDTH_LOG2;
        end else begin
            case (ximm)
                XIMM_256:  lw = 5'd8;
                XIMM_512:  lw = 5'd9;
                XIMM_1024: lw = 5'd10;
                XIMM_2048: lw = 5'd11;
                default:   lw = 5'd8;
            endcase
        end
        return lw;
    endfunction

endpackage

// File: rtl/t9990_blit_addr_map.sv
// Maps a pixel coordinate to a VRAM byte address and in-word pixel index.
// Latency: 1 cycle (registered output stage).
// Backpressure: loads only when en=1, otherwise holds; flush clears the stage.
module t9990_blit_addr_map
    import t9990_reg::*;
#(
    parameter int ADDR_W = 19,
    parameter int X_W    = 11,
    parameter int Y_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [X_W-1:0]    in_x,
    input  logic [Y_W-1:0]    in_y,
    input  logic              in_eol,
    input  logic              in_last,
    input  logic              p1,
    input  logic [1:0]        clrm,
    input  logic [4:0]        lw,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_pix,
    output logic              out_eol,
    output logic              out_last
);
    localparam int LIN_W = X_W + Y_W + 4;

    logic [LIN_W-1:0]  lin;
    logic [LIN_W-1:0]  byte_addr;
    logic [LIN_W-1:0]  p1_addr;
    logic [9:0]        xe;
    logic [9:0]        ye;
    logic [3:0]        pix_mask;
    logic              vld_d, vld_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [3:0]        pix_d, pix_q;
    logic              eol_d, eol_q;
    logic              last_d, last_q;

    // Address arithmetic and next-state for the output register.
    always_comb begin
        xe = 10'(in_x);
        ye = 10'(in_y);

        // Linear pixel index, scaled by bpp/8 = 2^clrm / 4, then word aligned.
        lin       = (LIN_W'(in_y) << lw) + LIN_W'(in_x);
        byte_addr = (lin << clrm) >> 2;
        byte_addr[1:0] = 2'b00;

        p1_addr       = '0;
        p1_addr[18]   = xe[9];
        p1_addr[17:8] = ye[9:0];
        p1_addr[7:2]  = xe[8:3];

        // Pixels per 32-bit word is 32/bpp; the index is X modulo that.
        pix_mask = 4'hF;
        case (clrm)
            CLRM_2BPP:  pix_mask = 4'hF;
            CLRM_4BPP:  pix_mask = 4'h7;
            CLRM_8BPP:  pix_mask = 4'h3;
            CLRM_16BPP: pix_mask = 4'h1;
            default:    pix_mask = 4'hF;
        endcase

        vld_d  = vld_q;
        addr_d = addr_q;
        pix_d  = pix_q;
        eol_d  = eol_q;
        last_d = last_q;
        if (flush) begin
            vld_d  = 1'b0;
            addr_d = '0;
            pix_d  = '0;
            eol_d  = 1'b0;
            last_d = 1'b0;
        end else if (en) begin
            vld_d  = in_vld;
            addr_d = p1 ? ADDR_W'(p1_addr) : ADDR_W'(byte_addr);
            pix_d  = p1 ? {1'b0, xe[2:0]} : (xe[3:0] & pix_mask);
            eol_d  = in_eol;
            last_d = in_last;
        end
    end

    // Output stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            pix_q  <= '0;
            eol_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            pix_q  <= pix_d;
            eol_q  <= eol_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_addr = addr_q;
    assign out_pix  = pix_q;
    assign out_eol  = eol_q;
    assign out_last = last_q;

endmodule

// File: rtl/t9990_blit_addr_gen.sv
// Blitter rectangle scanner: walks X-major over a NX*NY area and emits VRAM addresses.
// Latency: first beat 2 cycles after START, then one beat per cycle.
// Backpressure: whole pipeline stalls while OUT_VALID && !OUT_READY; outputs hold.
module t9990_blit_addr_gen
    import t9990_reg::*;
#(
    parameter int ADDR_W = 19,
    parameter int X_W    = 11,
    parameter int Y_W    = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [X_W-1:0]    SX,
    input  logic [Y_W-1:0]    SY,
    input  logic [X_W-1:0]    NX,
    input  logic [Y_W-1:0]    NY,
    input  logic              DIX,
    input  logic              DIY,
    input  logic [1:0]        CLRM,
    input  logic [1:0]        XIMM,
    input  logic              P1,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] ADDR,
    output logic [3:0]        PIX,
    output logic              EOL,
    output logic              LAST,
    output logic              BUSY
);
    state_e         state_q, state_d;
    logic [X_W-1:0] sx_q, sx_d, nx_m1_q, nx_m1_d, x_q, x_d, col_q, col_d;
    logic [Y_W-1:0] ny_m1_q, ny_m1_d, y_q, y_d, row_q, row_d;
    logic           dix_q, dix_d, diy_q, diy_d, p1_q, p1_d;
    logic [1:0]     clrm_q, clrm_d;
    logic [4:0]     lw_q, lw_d, lw_new;
    logic [X_W-1:0] mask_new, mask_cur;
    logic           c_vld_q, c_vld_d, c_eol_q, c_eol_d, c_last_q, c_last_d;
    logic [X_W-1:0] c_x_q, c_x_d;
    logic [Y_W-1:0] c_y_q, c_y_d;
    logic           advance, flush, row_end, scan_end;
    logic           out_vld, out_last;

    // Scan FSM, coordinate counters and the coordinate pipeline stage.
    always_comb begin
        lw_new = width_log2(XIMM, P1);
        if (lw_new > 5'(X_W)) lw_new = 5'(X_W);
        mask_new = {X_W{1'b1}} >> (5'(X_W) - lw_new);
        mask_cur = {X_W{1'b1}} >> (5'(X_W) - lw_q);

        advance  = !out_vld || OUT_READY;
        flush    = ABORT && (state_q != ST_IDLE);
        row_end  = (col_q == nx_m1_q);
        scan_end = row_end && (row_q == ny_m1_q);

        state_d  = state_q;
        sx_d     = sx_q;
        nx_m1_d  = nx_m1_q;
        ny_m1_d  = ny_m1_q;
        dix_d    = dix_q;
        diy_d    = diy_q;
        p1_d     = p1_q;
        clrm_d   = clrm_q;
        lw_d     = lw_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        row_d    = row_q;
        c_vld_d  = c_vld_q;
        c_x_d    = c_x_q;
        c_y_d    = c_y_q;
        c_eol_d  = c_eol_q;
        c_last_d = c_last_q;

        // A consumed coordinate leaves a bubble unless RUN refills it below.
        if (advance) c_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    // Size 0 wraps to all-ones, i.e. the maximum count.
                    sx_d    = SX & mask_new;
                    nx_m1_d = NX - X_W'(1);
                    ny_m1_d = NY - Y_W'(1);
                    dix_d   = DIX;
                    diy_d   = DIY;
                    p1_d    = P1;
                    clrm_d  = CLRM;
                    lw_d    = lw_new;
                    x_d     = SX & mask_new;
                    y_d     = SY;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    c_vld_d  = 1'b1;
                    c_x_d    = x_q;
                    c_y_d    = y_q;
                    c_eol_d  = row_end;
                    c_last_d = scan_end;
                    if (scan_end) begin
                        state_d = ST_DRAIN;
                    end else if (row_end) begin
                        col_d = '0;
                        row_d = row_q + Y_W'(1);
                        x_d   = sx_q;
                        y_d   = diy_q ? (y_q - Y_W'(1)) : (y_q + Y_W'(1));
                    end else begin
                        col_d = col_q + X_W'(1);
                        x_d   = (dix_q ? (x_q - X_W'(1)) : (x_q + X_W'(1))) & mask_cur;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_vld && OUT_READY && out_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            c_vld_d = 1'b0;
        end
    end

    // State, configuration and coordinate-stage registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            sx_q     <= '0;
            nx_m1_q  <= '0;
            ny_m1_q  <= '0;
            dix_q    <= 1'b0;
            diy_q    <= 1'b0;
            p1_q     <= 1'b0;
            clrm_q   <= '0;
            lw_q     <= 5'd8;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            c_vld_q  <= 1'b0;
            c_x_q    <= '0;
            c_y_q    <= '0;
            c_eol_q  <= 1'b0;
            c_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            nx_m1_q  <= nx_m1_d;
            ny_m1_q  <= ny_m1_d;
            dix_q    <= dix_d;
            diy_q    <= diy_d;
            p1_q     <= p1_d;
            clrm_q   <= clrm_d;
            lw_q     <= lw_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            row_q    <= row_d;
            c_vld_q  <= c_vld_d;
            c_x_q    <= c_x_d;
            c_y_q    <= c_y_d;
            c_eol_q  <= c_eol_d;
            c_last_q <= c_last_d;
        end
    end

    t9990_blit_addr_map #(
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_map (
        .clk      (CLK),
        .reset    (RESET),
        .en       (advance),
        .flush    (flush),
        .in_vld   (c_vld_q),
        .in_x     (c_x_q),
        .in_y     (c_y_q),
        .in_eol   (c_eol_q),
        .in_last  (c_last_q),
        .p1       (p1_q),
        .clrm     (clrm_q),
        .lw       (lw_q),
        .out_vld  (out_vld),
        .out_addr (ADDR),
        .out_pix  (PIX),
        .out_eol  (EOL),
        .out_last (out_last)
    );

    assign OUT_VALID = out_vld;
    assign LAST      = out_last;
    assign BUSY      = (state_q != ST_IDLE);

endmodule
